send_interval_mc: RTL and testbench
===================================

// Module: send_interval_mc
// PURPOSE
//  Multi-channel send-rate gate. Up to NCH producers raise ready[i]; the block grants one channel
//  at a time by round-robin and enforces a programmable interval (clock cycles) per grant.
//  Pre-wait mode delays each pass; post-wait mode enforces a gap after each release.
//  Sits between the frame producers and the shared transmitter.
// PARAMETERS
//  NCH    4   number of request channels (>=2)
//  CNT_W  32  width of interval and wait counter
//  CH_W   $clog2(NCH)  width of channel index (derived, not overridden)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous reset, active-high
//  interval      in   CNT_W  wait length in cycles, latched at grant
//  mode          in   1      0 = pre-wait, 1 = post-wait; latched at grant
//  ready         in   NCH    per-channel send request, level
//  ready_waited  out  NCH    gated request to transmitter; at most one bit high
//  sel_ch        out  CH_W   index of current/last granted channel
//  busy          out  1      state != IDLE
//  grant_pulse   out  1      1-cycle pulse on the cycle PASS is entered
//  abort_pulse   out  1      1-cycle pulse when a WAIT is abandoned
// BEHAVIOUR
//  Interface: one clock clk; reset rst is synchronous, active-high. Every flop is cleared on the
//   rst edge regardless of state. Next cycle: state=IDLE, ready_waited=0, busy=0, pulses=0,
//   sel_ch=NCH-1 (so ch0 has first priority).
//  States IDLE, WAIT, PASS, HOLD (registered). N = latched interval.
//  IDLE: if |ready, choose first requesting channel searching from (sel_ch+1) mod NCH upward with wrap.
//   Latch sel_ch, N and mode.
//   mode=0, N>0 -> WAIT; mode=0, N=0 or mode=1 -> PASS.
//  WAIT: occupies exactly N cycles; then PASS.
//   If ready[sel_ch]=0 in any WAIT cycle, including the last, -> IDLE, abort_pulse=1, no pass.
//  PASS: ready_waited[sel_ch] = ready[sel_ch] (combinational from state and input). Other bits are 0.
//   When ready[sel_ch]=0: mode=0 -> IDLE; mode=1, N>0 -> HOLD; mode=1, N=0 -> IDLE.
//  HOLD: occupies exactly N cycles with no grant; then IDLE. Requests are ignored, not lost (level).
//  Latency, request first high at cycle t in IDLE: mode0 -> PASS at t+N+1; mode1 -> PASS at t+1.
//   Release seen at r: mode1 -> IDLE at r+N+1; otherwise IDLE at r+1.
//   Minimum IDLE dwell is 1 cycle between grants.
//  interval/mode changes outside IDLE have no effect until the next grant.
//  Counter: CNT_W-bit down-counter. No wrap: N=2^CNT_W-1 gives exactly that many cycles.
//  grant_pulse is asserted the cycle state==PASS first holds. It is never asserted together with abort_pulse.
//  Simultaneous requests are resolved only by the round-robin pointer. A channel that was just
//   served is lowest priority next.
// STRUCTURE
//  send_interval_pkg: state encodings (ST_IDLE..ST_HOLD), MODE_PRE=1'b0 / MODE_POST=1'b1.
//  Sub-module rr_arbiter #(NCH): inputs req[NCH], last[CH_W]; outputs found, idx[CH_W]. Combinational.
//  Top: FSM, latched N/mode/sel, down-counter, output gating.
// TESTING
//  1 mode0, interval=3, ready[0] 0->1 at t, held -> WAIT t+1..t+3; ready_waited=0001 from t+4;
//    grant_pulse @t+4.
//  2 mode0, interval=5, ready[2] dropped at 3rd WAIT cycle -> abort_pulse 1 cycle, IDLE, ready_waited stays 0.
//  3 mode1, interval=4, ch1 pass released at r, ch3 requesting -> HOLD r+1..r+4, IDLE r+5,
//    ready_waited=1000 at r+6.
//  4 all ready=1111 held, interval=0, each release 1 cycle -> grant order 0,1,2,3,0.
//  5 interval=0 mode0 -> PASS 1 cycle after request, no WAIT. interval changed 2->9 during WAIT -> still 2 cycles.
//  6 rst=1 for one cycle during PASS/HOLD -> next cycle IDLE, ready_waited=0, sel_ch=NCH-1, next grant ch0.

Source files
------------

// File: rtl/send_interval_mc_pkg.sv
// Shared types and constants for the send_interval_mc rate gate.
// Contents:
//   state_e             FSM encoding (ST_IDLE, ST_WAIT, ST_PASS, ST_HOLD)
//   MODE_PRE/MODE_POST  values of the mode input (wait before / gap after a pass)
package send_interval_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PASS = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic MODE_PRE  = 1'b0;
    localparam logic MODE_POST = 1'b1;

endpackage

// File: rtl/send_interval_mc_if.sv
// Bus between the frame producers and the send_interval_mc gate.
// Signals:
//   interval      wait length in cycles, latched at grant
//   mode          0 = pre-wait, 1 = post-wait, latched at grant
//   ready         per-channel level request
//   ready_waited  gated request toward the transmitter (at most one bit high)
//   sel_ch        current / last granted channel
//   busy          gate is not idle
//   grant_pulse   one cycle on entry to PASS
//   abort_pulse   one cycle when a WAIT is abandoned
// Modports: master = producer side, slave = gate side.
interface send_interval_mc_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned CH_W = $clog2(NCH);

    logic [CNT_W-1:0] interval;
    logic             mode;
    logic [NCH-1:0]   ready;
    logic [NCH-1:0]   ready_waited;
    logic [CH_W-1:0]  sel_ch;
    logic             busy;
    logic             grant_pulse;
    logic             abort_pulse;

    modport master (
        output interval,
        output mode,
        output ready,
        input  ready_waited,
        input  sel_ch,
        input  busy,
        input  grant_pulse,
        input  abort_pulse
    );

    modport slave (
        input  interval,
        input  mode,
        input  ready,
        output ready_waited,
        output sel_ch,
        output busy,
        output grant_pulse,
        output abort_pulse
    );

endinterface

// File: rtl/send_interval_mc_rr_arbiter.sv
// Combinational round-robin search.
// Ports:
//   req    in   NCH   request vector
//   last   in   CH_W  previously granted index; the search starts just after it
//   found  out  1     some request is high
//   idx    out  CH_W  first requesting index at or after (last+1) mod NCH, with wrap
module send_interval_mc_rr_arbiter #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] last,
    output logic            found,
    output logic [CH_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = last;
        // Walk offsets from farthest to nearest so the nearest hit is written last.
        for (int unsigned i = NCH; i >= 1; i--) begin
            int unsigned     k;
            logic [CH_W-1:0] cand;
            k    = (32'(last) + i) % NCH;
            cand = CH_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/send_interval_mc.sv
// Multi-channel send-rate gate. Grants one requesting channel at a time (round robin)
// and enforces a programmable interval per grant: pre-wait mode delays the pass by
// N cycles, post-wait mode holds the gate closed for N cycles after release.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reset, active-high
//   bus   slave modport of send_interval_mc_if (interval, mode, ready in;
//         ready_waited, sel_ch, busy, grant_pulse, abort_pulse out)
module send_interval_mc
    import send_interval_mc_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    send_interval_mc_if.slave  bus
);

    localparam int unsigned CH_W = $clog2(NCH);

    state_e           state_q;
    logic [CH_W-1:0]  sel_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             grant_pulse_q;
    logic             abort_pulse_q;

    logic             arb_found;
    logic [CH_W-1:0]  arb_idx;
    logic [NCH-1:0]   ready_waited;

    send_interval_mc_rr_arbiter #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_arb (
        .req   (bus.ready),
        .last  (sel_q),
        .found (arb_found),
        .idx   (arb_idx)
    );

    // cnt_q counts down to 1 rather than 0, so a load of all-ones yields exactly
    // that many cycles without needing an extra counter bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= CH_W'(NCH - 1);
            n_q           <= '0;
            cnt_q         <= '0;
            mode_q        <= MODE_PRE;
            grant_pulse_q <= 1'b0;
            abort_pulse_q <= 1'b0;
        end else begin
            grant_pulse_q <= 1'b0;
            abort_pulse_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_found) begin
                        sel_q  <= arb_idx;
                        n_q    <= bus.interval;
                        cnt_q  <= bus.interval;
                        mode_q <= bus.mode;
                        if (bus.mode == MODE_PRE && bus.interval != '0) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q       <= ST_PASS;
                            grant_pulse_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!bus.ready[sel_q]) begin
                        state_q       <= ST_IDLE;
                        abort_pulse_q <= 1'b1;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q       <= ST_PASS;
                        grant_pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_PASS: begin
                    if (!bus.ready[sel_q]) begin
                        if (mode_q == MODE_POST && n_q != '0) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= n_q;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Pass-through is combinational so the transmitter sees a release immediately.
    always_comb begin
        ready_waited = '0;
        if (state_q == ST_PASS) begin
            ready_waited[sel_q] = bus.ready[sel_q];
        end
    end

    assign bus.ready_waited = ready_waited;
    assign bus.sel_ch       = sel_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.grant_pulse  = grant_pulse_q;
    assign bus.abort_pulse  = abort_pulse_q;

endmodule

// File: tb/tb_send_interval_mc.sv
// Directed bench for send_interval_mc. Inputs change and outputs are sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_send_interval_mc;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    send_interval_mc_if #(.NCH(4), .CNT_W(32)) bus ();

    send_interval_mc #(
        .NCH   (4),
        .CNT_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input int unsigned busy_e,
                            input int unsigned rw_e, input int unsigned gp_e);
        check_eq({tag, ".busy"}, 32'(bus.busy), busy_e);
        check_eq({tag, ".rw"}, 32'(bus.ready_waited), rw_e);
        check_eq({tag, ".gp"}, 32'(bus.grant_pulse), gp_e);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.ready    = 4'b0000;
        bus.interval = 32'd0;
        bus.mode     = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_outs("rst", 0, 0, 0);
        check_eq("rst.sel", 32'(bus.sel_ch), 3);
        check_eq("rst.abort", 32'(bus.abort_pulse), 0);

        // 1: pre-wait N=3 on ch0
        bus.interval = 32'd3;
        bus.mode     = 1'b0;
        bus.ready    = 4'b0001;
        tick(); chk_outs("t1.w1", 1, 0, 0);
        tick(); chk_outs("t1.w2", 1, 0, 0);
        tick(); chk_outs("t1.w3", 1, 0, 0);
        tick(); chk_outs("t1.pass", 1, 1, 1);
        check_eq("t1.sel", 32'(bus.sel_ch), 0);
        tick(); chk_outs("t1.pass2", 1, 1, 0);
        bus.ready = 4'b0000;
        tick(); chk_outs("t1.idle", 0, 0, 0);

        // 2: pre-wait N=5 on ch2, dropped in 3rd WAIT cycle
        bus.interval = 32'd5;
        bus.ready    = 4'b0100;
        tick(); chk_outs("t2.w1", 1, 0, 0);
        tick(); chk_outs("t2.w2", 1, 0, 0);
        tick(); chk_outs("t2.w3", 1, 0, 0);
        bus.ready = 4'b0000;
        tick(); chk_outs("t2.abort", 0, 0, 0);
        check_eq("t2.abort_pulse", 32'(bus.abort_pulse), 1);
        check_eq("t2.sel", 32'(bus.sel_ch), 2);
        tick();
        check_eq("t2.abort_end", 32'(bus.abort_pulse), 0);
        check_eq("t2.rw", 32'(bus.ready_waited), 0);

        // 3: post-wait N=4, ch1 pass then release with ch3 waiting
        bus.interval = 32'd4;
        bus.mode     = 1'b1;
        bus.ready    = 4'b0010;
        tick(); chk_outs("t3.pass", 1, 2, 1);
        check_eq("t3.sel", 32'(bus.sel_ch), 1);
        bus.ready = 4'b1000;
        tick(); chk_outs("t3.h1", 1, 0, 0);
        tick(); chk_outs("t3.h2", 1, 0, 0);
        tick(); chk_outs("t3.h3", 1, 0, 0);
        tick(); chk_outs("t3.h4", 1, 0, 0);
        tick(); chk_outs("t3.idle", 0, 0, 0);
        tick(); chk_outs("t3.pass3", 1, 8, 1);
        check_eq("t3.sel3", 32'(bus.sel_ch), 3);
        bus.ready = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        check_eq("t3.hold_end", 32'(bus.busy), 1);
        tick();
        check_eq("t3.idle2", 32'(bus.busy), 0);

        // 4: all channels held, N=0 pre-wait, grant order 0,1,2,3,0
        bus.interval = 32'd0;
        bus.mode     = 1'b0;
        bus.ready    = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int unsigned exp_ch;
            exp_ch = g % 4;
            tick();
            chk_outs($sformatf("t4.g%0d", g), 1, 1 << exp_ch, 1);
            check_eq($sformatf("t4.sel%0d", g), 32'(bus.sel_ch), exp_ch);
            bus.ready = 4'(4'b1111 & ~(4'b0001 << exp_ch));
            tick();
            check_eq($sformatf("t4.idle%0d", g), 32'(bus.busy), 0);
            bus.ready = (g == 4) ? 4'b0000 : 4'b1111;
        end
        tick();
        check_eq("t4.quiet", 32'(bus.busy), 0);

        // 5a: N=0 pre-wait passes one cycle after request (ch2, pointer at 0)
        bus.ready = 4'b0100;
        tick(); chk_outs("t5.pass", 1, 4, 1);
        bus.ready = 4'b0000;
        tick(); chk_outs("t5.idle", 0, 0, 0);
        // 5b: N=2, interval changed to 9 mid-WAIT
        bus.interval = 32'd2;
        bus.ready    = 4'b1000;
        tick(); chk_outs("t5.w1", 1, 0, 0);
        bus.interval = 32'd9;
        tick(); chk_outs("t5.w2", 1, 0, 0);
        tick(); chk_outs("t5.pass2", 1, 8, 1);
        bus.ready    = 4'b0000;
        bus.interval = 32'd3;
        bus.mode     = 1'b1;
        tick(); chk_outs("t5.idle2", 0, 0, 0);

        // 6: reset during PASS, then during HOLD
        bus.ready = 4'b0100;
        tick(); chk_outs("t6.pass", 1, 4, 1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk_outs("t6.rst1", 0, 0, 0);
        check_eq("t6.sel1", 32'(bus.sel_ch), 3);
        bus.ready = 4'b0101;
        tick(); chk_outs("t6.ch0", 1, 1, 1);
        check_eq("t6.sel_ch0", 32'(bus.sel_ch), 0);
        bus.ready = 4'b0000;
        tick(); chk_outs("t6.hold", 1, 0, 0);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk_outs("t6.rst2", 0, 0, 0);
        check_eq("t6.sel2", 32'(bus.sel_ch), 3);
        tick();
        check_eq("t6.stay_idle", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
